// File: rtl/trap_pkg.sv
// Shared types and constants for the trapezoidal shaper.
package trap_pkg;

    localparam int unsigned DEFAULT_W  = 16;
    localparam int unsigned DIFF_GUARD = 2;
    localparam int unsigned DIFF_WIDTH = DEFAULT_W + DIFF_GUARD;
    localparam int unsigned MAX_KL     = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } trap_state_e;

    function automatic logic params_valid(input logic [8:0] k, input logic [8:0] l);
        logic [9:0] sum;
        sum = {1'b0, k} + {1'b0, l};
        return (k != 9'd0) && (l >= k) && (sum <= 10'(MAX_KL));
    endfunction

endpackage

// File: rtl/trap_shaper_if.sv
// Sample stream into the shaper (current sample plus aligned delay taps) and shaped output.
interface trap_shaper_if #(
    parameter int unsigned W = 16
);
    logic signed [W-1:0] s_axis_tdata;
    logic                s_axis_tvalid;
    logic signed [W-1:0] xk_data;
    logic signed [W-1:0] xl_data;
    logic signed [W-1:0] xkl_data;
    logic signed [W-1:0] m_axis_tdata;
    logic                m_axis_tvalid;

    modport master (
        output s_axis_tdata, s_axis_tvalid, xk_data, xl_data, xkl_data,
        input  m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, xk_data, xl_data, xkl_data,
        output m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/trap_accumulator.sv
// Gated signed accumulator with synchronous clear; wraps modulo 2^WIDTH.
module trap_accumulator #(
    parameter int unsigned WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_addend,
    output logic signed [WIDTH-1:0] o_acc
);

    logic signed [WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_addend;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/trap_shaper.sv
// Trapezoidal shaper: tap gating, pole-zero correction, double accumulation, 5-stage pipeline.
// Define TRAP_OUT_SATURATE_EN to clamp the output instead of wrapping it.
module trap_shaper
    import trap_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 16,
    parameter int unsigned M_WIDTH          = 16,
    parameter int unsigned ACC_WIDTH        = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8:0]         kdelay,
    input  logic [8:0]         ldelay,
    input  logic [M_WIDTH-1:0] m_coef,
    input  logic [5:0]         shift,
    trap_shaper_if.slave       bus,
    output logic               settled
);

    localparam int unsigned W  = AXIS_TDATA_WIDTH;
    localparam int unsigned DW = W + DIFF_GUARD;

    trap_state_e r_state, w_state_next;
    logic [8:0]  r_k, r_l;
    logic [7:0]  r_cnt, w_cnt_base, w_cnt_next;
    logic [9:0]  w_kl;
    logic        w_par_ok, w_change, w_clr, w_accept;

    assign w_par_ok = params_valid(kdelay, ldelay);
    assign w_change = (kdelay != r_k) || (ldelay != r_l);
    assign w_kl     = {1'b0, kdelay} + {1'b0, ldelay};
    assign w_clr    = w_change || !w_par_ok;
    assign w_accept = bus.s_axis_tvalid && w_par_ok;

    // A parameter change restarts the fill, so the current sample counts as index 0.
    always_comb begin
        w_cnt_base   = w_change ? 8'd0 : r_cnt;
        w_cnt_next   = w_cnt_base;
        w_state_next = r_state;
        if (!w_par_ok) begin
            w_cnt_next   = 8'd0;
            w_state_next = IDLE;
        end else begin
            if (w_accept && ({2'b00, w_cnt_base} < w_kl)) begin
                w_cnt_next = w_cnt_base + 8'd1;
            end
            w_state_next = ({2'b00, w_cnt_next} == w_kl) ? RUN : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign settled = (r_state == RUN);

    logic signed [W-1:0]  w_xk, w_xl, w_xkl;
    logic signed [DW-1:0] w_xe, w_xke, w_xle, w_xkle, w_d;

    assign w_xk  = ({1'b0, w_cnt_base} < kdelay) ? '0 : bus.xk_data;
    assign w_xl  = ({1'b0, w_cnt_base} < ldelay) ? '0 : bus.xl_data;
    assign w_xkl = ({2'b00, w_cnt_base} < w_kl)  ? '0 : bus.xkl_data;

    assign w_xe   = {{DIFF_GUARD{bus.s_axis_tdata[W-1]}}, bus.s_axis_tdata};
    assign w_xke  = {{DIFF_GUARD{w_xk[W-1]}}, w_xk};
    assign w_xle  = {{DIFF_GUARD{w_xl[W-1]}}, w_xl};
    assign w_xkle = {{DIFF_GUARD{w_xkl[W-1]}}, w_xkl};
    assign w_d    = w_xe - w_xke - w_xle + w_xkle;

    logic                        r_v1, r_v2, r_v3, r_v4, r_v5;
    logic signed [DW-1:0]        r_d;
    logic signed [ACC_WIDTH-1:0] r_md, r_rterm;
    logic signed [ACC_WIDTH-1:0] w_dx, w_mx, w_md, w_p, w_s;
    logic signed [W-1:0]         r_out, w_out;

    assign w_dx = {{(ACC_WIDTH - DW){r_d[DW-1]}}, r_d};
    assign w_mx = {{(ACC_WIDTH - M_WIDTH){1'b0}}, m_coef};
    assign w_md = w_mx * w_dx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_l     <= '0;
            r_cnt   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_v4    <= 1'b0;
            r_v5    <= 1'b0;
            r_d     <= '0;
            r_md    <= '0;
            r_rterm <= '0;
            r_out   <= '0;
        end else begin
            r_k   <= kdelay;
            r_l   <= ldelay;
            r_cnt <= w_cnt_next;
            // The new sample survives a restart; everything already in flight is dropped.
            r_v1  <= w_accept;
            r_v2  <= r_v1 && !w_clr;
            r_v3  <= r_v2 && !w_clr;
            r_v4  <= r_v3 && !w_clr;
            r_v5  <= r_v4 && !w_clr;
            if (w_accept) begin
                r_d <= w_d;
            end
            if (r_v1) begin
                r_md <= w_md;
            end
            if (r_v2) begin
                r_rterm <= w_p + r_md;
            end
            if (r_v4) begin
                r_out <= w_out;
            end
        end
    end

    trap_accumulator #(
        .WIDTH (ACC_WIDTH)
    ) u_acc_p (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_en     (r_v1),
        .i_addend (w_dx),
        .o_acc    (w_p)
    );

    trap_accumulator #(
        .WIDTH (ACC_WIDTH)
    ) u_acc_s (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_en     (r_v3),
        .i_addend (r_rterm),
        .o_acc    (w_s)
    );

`ifdef TRAP_OUT_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [ACC_WIDTH-W:0]        w_top;

    assign w_shifted = w_s >>> shift;
    assign w_top     = w_shifted[ACC_WIDTH-1:W-1];

    // In range only when every bit above the output sign bit matches it.
    always_comb begin
        w_out = w_shifted[W-1:0];
        if (!((&w_top) || !(|w_top))) begin
            w_out = w_top[ACC_WIDTH-W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign w_out = W'(w_s >>> shift);
`endif

    assign bus.m_axis_tdata  = r_out;
    assign bus.m_axis_tvalid = r_v5;

endmodule
